// File: rtl/ex_stage_params.sv
// Execute-stage types shared with the io stage.
//   load_type_t    : which load extraction/merge the io stage applies
//   EXToIOData     : execute-stage result bundle, qualified by valid
//   WBExceptionBus : exception / eret flush indication from write-back
package ex_stage_params;

  typedef enum logic [2:0] {
    LOAD_NONE       = 3'd0,
    LOAD_BYTE       = 3'd1,
    LOAD_HALF       = 3'd2,
    LOAD_WORD       = 3'd3,
    LOAD_WORD_LEFT  = 3'd4,
    LOAD_WORD_RIGHT = 3'd5
  } load_type_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [31:0] alu_result;
    logic [4:0]  write_register;
    logic        register_write;
    load_type_t  load_type;
    logic        memory_io_unsigned;
    logic [1:0]  memory_address_final;
    logic [31:0] multi_use_register_data;  // rt value, used by LWL/LWR merges
    logic [31:0] source_register_data;     // rs value, written by MTHI/MTLO
    logic        result_high;
    logic        result_low;
    logic        high_low_write;
    logic        multiply_valid;
    logic [63:0] multiply_result;
    logic        divide_valid;
    logic        move_from_cp0;
    logic        move_to_cp0;
    logic [7:0]  cp0_address;
    logic        exception_valid;
    logic        eret_flush;
    logic [4:0]  exception_code;
    logic        branch_delay_slot;
    logic [31:0] bad_virtual_address;
  } EXToIOData;

  typedef struct packed {
    logic exception_valid;
    logic eret_flush;
  } WBExceptionBus;

endpackage

// File: rtl/io_stage_params.sv
// Io-stage types and constants.
//   HI_LO_RESET_VALUE  : value HI and LO take on reset
//   IOToWBData         : io -> write-back bundle
//   IOToIDBackPassData : io -> decode forwarding bundle
package io_stage_params;

  localparam logic [31:0] HI_LO_RESET_VALUE = 32'h0;

  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [31:0] final_result;
    logic [4:0]  write_register;
    logic        register_write;
    logic        move_from_cp0;
    logic        move_to_cp0;
    logic [7:0]  cp0_address;
    logic        exception_valid;
    logic        eret_flush;
    logic [4:0]  exception_code;
    logic        branch_delay_slot;
    logic [31:0] bad_virtual_address;
  } IOToWBData;

  typedef struct packed {
    logic        valid;
    logic        data_valid;
    logic [4:0]  write_register;
    logic [31:0] write_data;
  } IOToIDBackPassData;

endpackage

// File: rtl/load_aligner.sv
// Combinational load extraction and unaligned-word merge.
//   read_data   : data SRAM read word
//   address     : low two bits of the effective address
//   load_type   : LB/LH/LW/LWL/LWR selector
//   is_unsigned : zero-extend byte/half loads
//   rt          : current rt value merged by LWL/LWR
//   result      : aligned load result
module load_aligner
  import ex_stage_params::*;
(
  input  logic [31:0] read_data,
  input  logic [1:0]  address,
  input  load_type_t  load_type,
  input  logic        is_unsigned,
  input  logic [31:0] rt,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = read_data[{address, 3'b000} +: 8];
  assign half_sel = address[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    // NOTE: default assignment first so every path drives result and no latch is inferred.
    result = read_data;
    case (load_type)
      LOAD_BYTE: result = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      LOAD_HALF: result = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      LOAD_WORD_LEFT: begin
        case (address)
          2'd0:    result = {read_data[7:0],  rt[23:0]};
          2'd1:    result = {read_data[15:0], rt[15:0]};
          2'd2:    result = {read_data[23:0], rt[7:0]};
          default: result = read_data;
        endcase
      end
      LOAD_WORD_RIGHT: begin
        case (address)
          2'd0:    result = read_data;
          2'd1:    result = {rt[31:24], read_data[31:8]};
          2'd2:    result = {rt[31:16], read_data[31:16]};
          default: result = {rt[31:8],  read_data[31:24]};
        endcase
      end
      default: result = read_data;
    endcase
  end

endmodule

// File: rtl/io_stage.sv
// Memory-return (io) pipeline stage: valid/handshake, load alignment,
// HI/LO registers and result selection.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   wb_allow_in             : write-back accepts this cycle
//   io_allow_in             : io accepts ex_to_io_bus this cycle
//   ex_to_io_bus            : execute-stage bundle
//   data_ram_read_data      : SRAM read word for the resident load
//   divide_result_valid/... : live divider outputs for the resident divide
//   wb_exception_bus        : flush request from write-back
//   io_to_wb_bus            : bundle to write-back
//   io_to_id_back_pass_bus  : forwarding bundle to decode
module io_stage
  import ex_stage_params::*;
  import io_stage_params::*;
#(
  parameter logic [31:0] HI_LO_RESET = HI_LO_RESET_VALUE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_allow_in,
  output logic              io_allow_in,
  input  EXToIOData         ex_to_io_bus,
  input  logic [31:0]       data_ram_read_data,
  input  logic              divide_result_valid,
  input  logic [31:0]       divide_quotient,
  input  logic [31:0]       divide_remainder,
  input  WBExceptionBus     wb_exception_bus,
  output IOToWBData         io_to_wb_bus,
  output IOToIDBackPassData io_to_id_back_pass_bus
);

  logic        io_valid;
  EXToIOData   io_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        io_ready_go;
  logic        wb_flush;
  logic        hi_lo_commit;
  logic [31:0] load_result;
  logic [31:0] final_result;

  // A resident divide waits for the live divider; everything else is single-cycle.
  assign io_ready_go  = !(io_data.divide_valid && !divide_result_valid);
  assign io_allow_in  = !io_valid || (io_ready_go && wb_allow_in);
  assign wb_flush     = wb_exception_bus.exception_valid || wb_exception_bus.eret_flush;
  assign hi_lo_commit = io_valid && io_ready_go && wb_allow_in &&
                        !io_data.exception_valid && !io_data.eret_flush && !wb_flush;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset)            io_valid <= 1'b0;
    else if (wb_flush)    io_valid <= 1'b0;   // flush wins over a new accept
    else if (io_allow_in) io_valid <= ex_to_io_bus.valid;
  end

  // NOTE: the payload register is deliberately not reset; io_valid qualifies every use of it.
  always_ff @(posedge clock) begin
    if (ex_to_io_bus.valid && io_allow_in) io_data <= ex_to_io_bus;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= HI_LO_RESET;
      lo <= HI_LO_RESET;
    end else if (hi_lo_commit) begin
      if (io_data.multiply_valid) begin
        hi <= io_data.multiply_result[63:32];
        lo <= io_data.multiply_result[31:0];
      end else if (io_data.divide_valid) begin
        lo <= divide_quotient;
        hi <= divide_remainder;
      end else if (io_data.high_low_write) begin
        if (io_data.result_high) hi <= io_data.source_register_data;
        else                     lo <= io_data.source_register_data;
      end
    end
  end

  load_aligner u_load_aligner (
    .read_data   (data_ram_read_data),
    .address     (io_data.memory_address_final),
    .load_type   (io_data.load_type),
    .is_unsigned (io_data.memory_io_unsigned),
    .rt          (io_data.multi_use_register_data),
    .result      (load_result)
  );

  // MFHI/MFLO see HI/LO before this cycle's commit, since the registers update at the edge.
  always_comb begin
    final_result = io_data.alu_result;
    if (io_data.load_type != LOAD_NONE)
      final_result = load_result;
    else if (io_data.result_high && !io_data.high_low_write)
      final_result = hi;
    else if (io_data.result_low && !io_data.high_low_write)
      final_result = lo;
  end

  always_comb begin
    io_to_wb_bus                     = '0;
    io_to_wb_bus.valid               = io_valid && io_ready_go;
    io_to_wb_bus.program_count       = io_data.program_count;
    io_to_wb_bus.final_result        = final_result;
    io_to_wb_bus.write_register      = io_data.write_register;
    io_to_wb_bus.register_write      = io_data.register_write;
    io_to_wb_bus.move_from_cp0       = io_data.move_from_cp0;
    io_to_wb_bus.move_to_cp0         = io_data.move_to_cp0;
    io_to_wb_bus.cp0_address         = io_data.cp0_address;
    io_to_wb_bus.exception_valid     = io_data.exception_valid;
    io_to_wb_bus.eret_flush          = io_data.eret_flush;
    io_to_wb_bus.exception_code      = io_data.exception_code;
    io_to_wb_bus.branch_delay_slot   = io_data.branch_delay_slot;
    io_to_wb_bus.bad_virtual_address = io_data.bad_virtual_address;
  end

  // Decode may stall on valid alone; data_valid says the value can be forwarded now.
  always_comb begin
    io_to_id_back_pass_bus                = '0;
    io_to_id_back_pass_bus.valid          = io_valid && io_data.register_write;
    io_to_id_back_pass_bus.data_valid     = io_valid && io_data.register_write &&
                                            io_ready_go && !io_data.move_from_cp0;
    io_to_id_back_pass_bus.write_register = io_data.write_register;
    io_to_id_back_pass_bus.write_data     = final_result;
  end

endmodule

// File: tb/tb_io_stage.sv
// Self-checking bench for io_stage: directed corner cases followed by
// randomized traffic compared against a behavioural model.
module tb_io_stage;
  import ex_stage_params::*;
  import io_stage_params::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              wb_allow_in;
  logic              io_allow_in;
  EXToIOData         ex_bus;
  logic [31:0]       rdata;
  logic              drv;
  logic [31:0]       dq;
  logic [31:0]       dr;
  WBExceptionBus     wbx;
  IOToWBData         wb_bus;
  IOToIDBackPassData bp;

  io_stage dut (
    .clock                  (clock),
    .reset                  (reset),
    .wb_allow_in            (wb_allow_in),
    .io_allow_in            (io_allow_in),
    .ex_to_io_bus           (ex_bus),
    .data_ram_read_data     (rdata),
    .divide_result_valid    (drv),
    .divide_quotient        (dq),
    .divide_remainder       (dr),
    .wb_exception_bus       (wbx),
    .io_to_wb_bus           (wb_bus),
    .io_to_id_back_pass_bus (bp)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid;
  EXToIOData   m_bus;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  bit          model_live;

  function automatic logic [31:0] exp_result(input EXToIOData b, input logic [31:0] mem,
                                             input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] w;
    logic [63:0] rt;
    logic [63:0] v;
    int sh;
    w  = {32'h0, mem};
    rt = {32'h0, b.multi_use_register_data};
    v  = w;
    case (b.load_type)
      LOAD_BYTE: begin
        v = (w >> (8 * int'(b.memory_address_final))) & 64'hFF;
        if (!b.memory_io_unsigned && v >= 64'd128) v = v + 64'hFFFF_FF00;
      end
      LOAD_HALF: begin
        v = (w >> (16 * int'(b.memory_address_final[1]))) & 64'hFFFF;
        if (!b.memory_io_unsigned && v >= 64'd32768) v = v + 64'hFFFF_0000;
      end
      LOAD_WORD: v = w;
      LOAD_WORD_LEFT: begin
        sh = 8 * (3 - int'(b.memory_address_final));
        v  = (w << sh) | (rt & ((64'd1 << sh) - 64'd1));
      end
      LOAD_WORD_RIGHT: begin
        sh = 8 * int'(b.memory_address_final);
        v  = (w >> sh) | (rt & ~(64'hFFFF_FFFF >> sh));
      end
      default: begin
        if (b.result_high && !b.high_low_write)     v = {32'h0, hi};
        else if (b.result_low && !b.high_low_write) v = {32'h0, lo};
        else                                        v = {32'h0, b.alu_result};
      end
    endcase
    return v[31:0];
  endfunction

  task automatic compare_model();
    logic ready;
    ready = !(m_bus.divide_valid && !drv);
    check("allow_in", io_allow_in, !m_valid || (ready && wb_allow_in));
    check("wb_valid", wb_bus.valid, m_valid && ready);
    check("bp_valid", bp.valid, m_valid && m_bus.register_write);
    check("bp_data_valid", bp.data_valid,
          m_valid && m_bus.register_write && ready && !m_bus.move_from_cp0);
    if (m_valid && ready) begin
      check("final_result", wb_bus.final_result, exp_result(m_bus, rdata, m_hi, m_lo));
      check("program_count", wb_bus.program_count, m_bus.program_count);
      check("write_register", wb_bus.write_register, m_bus.write_register);
      if (m_bus.register_write)
        check("bp_write_data", bp.write_data, exp_result(m_bus, rdata, m_hi, m_lo));
    end
  endtask

  task automatic update_model();
    logic ready, allow, flush;
    if (reset) begin
      m_valid = 1'b0;
      m_hi    = 32'h0;
      m_lo    = 32'h0;
      return;
    end
    ready = !(m_bus.divide_valid && !drv);
    allow = !m_valid || (ready && wb_allow_in);
    flush = wbx.exception_valid || wbx.eret_flush;
    if (m_valid && ready && wb_allow_in && !flush && !m_bus.exception_valid && !m_bus.eret_flush) begin
      if (m_bus.multiply_valid) begin
        m_hi = m_bus.multiply_result[63:32];
        m_lo = m_bus.multiply_result[31:0];
      end else if (m_bus.divide_valid) begin
        m_lo = dq;
        m_hi = dr;
      end else if (m_bus.high_low_write) begin
        if (m_bus.result_high) m_hi = m_bus.source_register_data;
        else                   m_lo = m_bus.source_register_data;
      end
    end
    if (allow && ex_bus.valid) m_bus = ex_bus;
    if (flush)      m_valid = 1'b0;
    else if (allow) m_valid = ex_bus.valid;
  endtask

  // Inputs are driven just after a falling edge; outputs are sampled 1ns later.
  task automatic cycle();
    #1;
    if (model_live) compare_model();
    @(posedge clock);
    update_model();
    model_live = 1'b1;
    @(negedge clock);
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic EXToIOData mk_base();
    EXToIOData b;
    b                = '0;
    b.valid          = 1'b1;
    b.program_count  = $urandom;
    b.alu_result     = $urandom;
    b.write_register = 5'($urandom_range(1, 31));
    b.register_write = 1'b1;
    return b;
  endfunction

  function automatic EXToIOData mk_load(input load_type_t t, input logic uns,
                                        input logic [1:0] addr, input logic [31:0] rt);
    EXToIOData b;
    b                         = mk_base();
    b.load_type               = t;
    b.memory_io_unsigned      = uns;
    b.memory_address_final    = addr;
    b.multi_use_register_data = rt;
    return b;
  endfunction

  function automatic EXToIOData mk_mult(input logic [63:0] res);
    EXToIOData b;
    b                 = mk_base();
    b.register_write  = 1'b0;
    b.multiply_valid  = 1'b1;
    b.multiply_result = res;
    return b;
  endfunction

  function automatic EXToIOData mk_div();
    EXToIOData b;
    b                = mk_base();
    b.register_write = 1'b0;
    b.divide_valid   = 1'b1;
    return b;
  endfunction

  function automatic EXToIOData mk_mf(input logic high);
    EXToIOData b;
    b             = mk_base();
    b.result_high = high;
    b.result_low  = !high;
    return b;
  endfunction

  function automatic EXToIOData mk_mt(input logic high, input logic [31:0] src);
    EXToIOData b;
    b                      = mk_base();
    b.register_write       = 1'b0;
    b.high_low_write       = 1'b1;
    b.result_high          = high;
    b.result_low           = !high;
    b.source_register_data = src;
    return b;
  endfunction

  function automatic EXToIOData rand_ex();
    EXToIOData b;
    int kind;
    kind = $urandom_range(0, 8);
    case (kind)
      0:       b = mk_base();
      1:       b = mk_load(load_type_t'($urandom_range(1, 5)), 1'($urandom_range(0, 1)),
                           2'($urandom_range(0, 3)), $urandom);
      2:       b = mk_mult({$urandom, $urandom});
      3:       b = mk_div();
      4:       b = mk_mf(1'b1);
      5:       b = mk_mf(1'b0);
      6:       b = mk_mt(1'b1, $urandom);
      7:       b = mk_mt(1'b0, $urandom);
      default: begin
        b               = mk_base();
        b.move_from_cp0 = 1'b1;
        b.cp0_address   = 8'($urandom);
      end
    endcase
    b.valid           = ($urandom_range(0, 4) != 0);
    b.exception_valid = ($urandom_range(0, 15) == 0);
    b.eret_flush      = ($urandom_range(0, 31) == 0);
    return b;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    reset       = 1'b1;
    wb_allow_in = 1'b1;
    ex_bus      = '0;
    rdata       = 32'h0;
    drv         = 1'b0;
    dq          = 32'h0;
    dr          = 32'h0;
    wbx         = '0;
    m_bus       = '0;
    m_valid     = 1'b0;
    m_hi        = 32'h0;
    m_lo        = 32'h0;
    model_live  = 1'b0;

    cycle();
    cycle();
    reset = 1'b0;
    #1;
    check("rst_allow_in", io_allow_in, 1'b1);
    check("rst_wb_valid", wb_bus.valid, 1'b0);
    check("rst_bp_valid", bp.valid, 1'b0);

    // HI after reset
    ex_bus = mk_mf(1'b1);
    cycle();
    ex_bus = '0;
    #1 check("rst_hi", wb_bus.final_result, 32'h0);
    cycle();

    // LB / LBU at address 3
    ex_bus = mk_load(LOAD_BYTE, 1'b0, 2'd3, 32'h0);
    cycle();
    ex_bus = '0;
    rdata  = 32'h80FF_1234;
    #1 check("lb_addr3", wb_bus.final_result, 32'hFFFF_FF80);
    cycle();
    ex_bus = mk_load(LOAD_BYTE, 1'b1, 2'd3, 32'h0);
    cycle();
    ex_bus = '0;
    #1 check("lbu_addr3", wb_bus.final_result, 32'h0000_0080);
    cycle();

    // LWL addr 1, LWR addr 2
    ex_bus = mk_load(LOAD_WORD_LEFT, 1'b0, 2'd1, 32'h1122_3344);
    cycle();
    ex_bus = '0;
    rdata  = 32'hAABB_CCDD;
    #1 check("lwl_addr1", wb_bus.final_result, 32'hCCDD_3344);
    cycle();
    ex_bus = mk_load(LOAD_WORD_RIGHT, 1'b0, 2'd2, 32'h1122_3344);
    cycle();
    ex_bus = '0;
    #1 check("lwr_addr2", wb_bus.final_result, 32'h1122_AABB);
    cycle();

    // MULT then back-to-back MFHI / MFLO
    ex_bus = mk_mult(64'h0000_0001_FFFF_FFFE);
    cycle();
    ex_bus = mk_mf(1'b1);
    cycle();
    ex_bus = mk_mf(1'b0);
    #1 check("mult_mfhi", wb_bus.final_result, 32'h1);
    cycle();
    ex_bus = '0;
    #1 check("mult_mflo", wb_bus.final_result, 32'hFFFF_FFFE);
    cycle();

    // DIV pending for 5 cycles, then result
    ex_bus = mk_div();
    cycle();
    ex_bus = mk_mf(1'b0);
    drv    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("div_wait_allow_in", io_allow_in, 1'b0);
      check("div_wait_wb_valid", wb_bus.valid, 1'b0);
      cycle();
    end
    drv = 1'b1;
    dq  = 32'd7;
    dr  = 32'd3;
    #1;
    check("div_done_allow_in", io_allow_in, 1'b1);
    check("div_done_wb_valid", wb_bus.valid, 1'b1);
    cycle();
    drv    = 1'b0;
    ex_bus = mk_mf(1'b1);
    #1 check("div_lo", wb_bus.final_result, 32'd7);
    cycle();
    ex_bus = '0;
    #1 check("div_hi", wb_bus.final_result, 32'd3);
    cycle();

    // MTHI killed by a write-back exception
    ex_bus = mk_mt(1'b1, 32'hDEAD_BEEF);
    cycle();
    ex_bus              = '0;
    wbx.exception_valid = 1'b1;
    cycle();
    wbx = '0;
    #1;
    check("exc_wb_valid", wb_bus.valid, 1'b0);
    check("exc_allow_in", io_allow_in, 1'b1);
    ex_bus = mk_mf(1'b1);
    cycle();
    ex_bus = '0;
    #1 check("exc_hi_kept", wb_bus.final_result, 32'd3);
    cycle();

    // LW resident across a 3-cycle write-back stall
    ex_bus = mk_load(LOAD_WORD, 1'b0, 2'd0, 32'h0);
    rdata  = 32'h1234_5678;
    cycle();
    ex_bus      = mk_mf(1'b0);
    wb_allow_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_allow_in", io_allow_in, 1'b0);
      check("stall_wb_valid", wb_bus.valid, 1'b1);
      check("stall_data_valid", bp.data_valid, 1'b1);
      check("stall_result", wb_bus.final_result, 32'h1234_5678);
      cycle();
    end
    wb_allow_in = 1'b1;
    cycle();
    ex_bus = '0;
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset               = ($urandom_range(0, 199) == 0);
      wb_allow_in         = ($urandom_range(0, 3) != 0);
      wbx.exception_valid = ($urandom_range(0, 39) == 0);
      wbx.eret_flush      = ($urandom_range(0, 59) == 0);
      rdata               = $urandom;
      drv                 = ($urandom_range(0, 2) == 0);
      dq                  = $urandom;
      dr                  = $urandom;
      ex_bus              = rand_ex();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
